stream_mux: RTL and testbench
=============================

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter N_CH, default 3, number of input channels (2..16).
REQ-002 Parameter DATA_W, default 8, data width per channel in bits.
REQ-003 Derived SEL_W = ceil(log2(N_CH)), minimum 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SEL_W  channel index used in fixed mode.
REQ-008 in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 in_valid  input  N_CH  per-channel beat valid.
REQ-010 in_last  input  N_CH  per-channel end-of-packet marker.
REQ-011 in_ready  output  N_CH  per-channel ready; at most one bit high in any cycle.
REQ-012 out_data  output  DATA_W  registered output beat.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_last  output  1  output end-of-packet marker.
REQ-015 out_ch  output  SEL_W  source channel of the current output beat.
REQ-016 out_ready  input  1  downstream ready.
REQ-017 err_sel  output  1  one-cycle pulse for an out-of-range select in fixed mode.

Function
REQ-018 Transfer rule: a beat moves when valid and ready are both high in the same cycle, on both the input and output sides.
REQ-019 Output stage is one register; the stage can load when out_valid=0 or out_ready=1.
REQ-020 Latency: a beat accepted on an input in cycle t SHALL appear on out_data/out_last/out_ch with out_valid=1 in cycle t+1.
REQ-021 out_data, out_last and out_ch SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 FSM states: IDLE (no packet in progress) and LOCKED (packet in progress on channel gnt).
REQ-023 IDLE, mode=0: candidate = sel when sel < N_CH; otherwise no candidate.
REQ-024 IDLE, mode=1: candidate = first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo N_CH, ending at ptr.
REQ-025 in_ready[candidate] SHALL be high when the output stage can load; all other in_ready bits SHALL be 0.
REQ-026 Accepting a beat in IDLE with in_last=0: register gnt = candidate and move to LOCKED.
REQ-027 Accepting a beat in IDLE with in_last=1: remain in IDLE (single-beat packet).
REQ-028 LOCKED: only in_ready[gnt] may be high; mode and sel are ignored until the FSM returns to IDLE.
REQ-029 LOCKED: accepting a beat with in_last=1 returns the FSM to IDLE.
REQ-030 Round-robin pointer ptr SHALL be set to the granted channel on the first beat of each packet in mode=1, and SHALL be unchanged in mode=0.
REQ-031 In IDLE with mode=0 and sel >= N_CH, err_sel SHALL pulse high the following cycle; it repeats each cycle the condition holds, and all in_ready bits stay 0.
REQ-032 Output drain and a new input accept in the same cycle SHALL sustain one beat per cycle with no bubble.
REQ-033 A mode change in IDLE takes effect in the same cycle.

Reset
REQ-034 While rst=1 at a clock edge: FSM = IDLE, ptr = N_CH-1 (so channel 0 is first in round-robin), gnt=0, out_valid=0, out_last=0, out_data=0, out_ch=0, err_sel=0.
REQ-035 in_ready SHALL be all-zero during any cycle with rst=1.
REQ-036 Reset mid-packet SHALL discard the LOCKED state and any pending output beat with no partial completion.

Verification (N_CH=3, DATA_W=8)
REQ-037 Fixed mode: mode=0, sel=1, ch1 sends 0x11,0x22(last), out_ready=1 -> out_data 0x11 then 0x22, out_ch=1, out_last=1 on the second beat, 1-cycle latency.
REQ-038 Round-robin: all channels valid with single-beat packets, mode=1 -> out_ch sequence 0,1,2,0.
REQ-039 Packet lock: ch0 sends 3 beats with last on the third while ch1 is valid -> no ch1 beat before ch0 last; ch1 granted the next cycle.
REQ-040 Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data held, in_ready all 0, no beat lost or duplicated.
REQ-041 Bad select: mode=0, sel=3 for 2 cycles -> err_sel high for 2 cycles, in_ready=000, out_valid=0.
REQ-042 Reset mid-packet: rst=1 for 1 cycle during LOCKED on ch2 -> out_valid=0, next grant uses ch0 first in mode=1.

Source files
------------

// File: rtl/stream_mux.sv
// ============================================================================
// Module   : stream_mux
// Purpose  : N-channel packet stream multiplexer with fixed or round-robin
//            arbitration, packet locking and a single registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux #(
   parameter  int N_CH   = 3,
   parameter  int DATA_W = 8,
   localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [N_CH-1:0]          in_valid,
   input  logic [N_CH-1:0]          in_last,
   output logic [N_CH-1:0]          in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready,
   output logic                     err_sel
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [SEL_W:0]   c_N_CH    = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(N_CH - 1);

   state_t              r_state;
   logic [SEL_W-1:0]    r_ptr;
   logic [SEL_W-1:0]    r_gnt;
   logic                r_out_valid;
   logic                r_out_last;
   logic [DATA_W-1:0]   r_out_data;
   logic [SEL_W-1:0]    r_out_ch;
   logic                r_err_sel;

   logic [DATA_W-1:0]   w_ch_data [N_CH];
   logic                w_can_load;
   logic                w_sel_ok;
   logic [SEL_W-1:0]    w_cand;
   logic                w_cand_ok;
   logic [N_CH-1:0]     w_ready;
   logic                w_accept;
   logic                w_acc_last;

   for (genvar g = 0; g < N_CH; g++) begin : g_unpack
      assign w_ch_data[g] = in_data[g*DATA_W +: DATA_W];
   end

   assign w_can_load = !r_out_valid || out_ready;
   assign w_sel_ok   = ({1'b0, sel} < c_N_CH);

   // Round-robin scans from the farthest offset down so the nearest channel after r_ptr wins.
   always_comb begin : p_cand
      int               v_j;
      logic [SEL_W-1:0] v_idx;
      v_j       = 0;
      v_idx     = '0;
      w_cand    = r_gnt;
      w_cand_ok = 1'b0;
      if (r_state == ST_LOCKED) begin
         w_cand    = r_gnt;
         w_cand_ok = 1'b1;
      end else if (!mode) begin
         w_cand    = sel;
         w_cand_ok = w_sel_ok;
      end else begin
         for (int i = N_CH; i >= 1; i--) begin
            v_j = int'(r_ptr) + i;
            if (v_j >= N_CH) begin
               v_j = v_j - N_CH;
            end
            v_idx = SEL_W'(v_j);
            if (in_valid[v_idx]) begin
               w_cand    = v_idx;
               w_cand_ok = 1'b1;
            end
         end
      end
   end

   assign w_ready    = (w_cand_ok && w_can_load && !rst) ? (N_CH'(1) << w_cand) : '0;
   assign w_accept   = |(w_ready & in_valid);
   assign w_acc_last = |(w_ready & in_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= c_LAST_CH;
         r_gnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_err_sel   <= 1'b0;
      end else begin
         r_err_sel <= (r_state == ST_IDLE) && !mode && !w_sel_ok;

         if (w_can_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
               r_out_data <= w_ch_data[w_cand];
               r_out_last <= w_acc_last;
               r_out_ch   <= w_cand;
            end
         end

         if (w_accept) begin
            case (r_state)
               ST_IDLE: begin
                  if (mode) begin
                     r_ptr <= w_cand;
                  end
                  if (!w_acc_last) begin
                     r_gnt   <= w_cand;
                     r_state <= ST_LOCKED;
                  end
               end
               ST_LOCKED: begin
                  if (w_acc_last) begin
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign in_ready  = w_ready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_ch    = r_out_ch;
   assign err_sel   = r_err_sel;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ============================================================================
// Module   : tb_stream_mux
// Purpose  : Self-checking bench for stream_mux (N_CH=3, DATA_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [23:0] in_data;
   logic [2:0]  in_valid;
   logic [2:0]  in_last;
   logic [2:0]  in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  out_ch;
   logic        out_ready;
   logic        err_sel;

   always #5 clk = ~clk;

   stream_mux #(.N_CH(3), .DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ch    (out_ch),
      .out_ready (out_ready),
      .err_sel   (err_sel)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: packet-level view of the arbiter and output register.
   bit m_locked, m_ov, m_ol, m_err;
   int m_gnt, m_ptr, m_od, m_och;

   function automatic logic [2:0] m_ready();
      logic [2:0] r;
      int         c;
      r = '0;
      if (rst) return r;
      if (m_ov && !out_ready) return r;
      if (m_locked) begin
         r[m_gnt] = 1'b1;
         return r;
      end
      if (!mode) begin
         if (sel < 3) r[sel] = 1'b1;
         return r;
      end
      for (int k = 1; k <= 3; k++) begin
         c = (m_ptr + k) % 3;
         if (in_valid[c]) begin
            r[c] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin : model
      logic [2:0] r;
      int         c;
      bit         can, acc;
      cyc++;
      r   = m_ready();
      can = !m_ov || out_ready;
      acc = |(r & in_valid);
      c   = 0;
      for (int k = 0; k < 3; k++) if (r[k]) c = k;
      if (rst) begin
         m_locked = 0; m_gnt = 0; m_ptr = 2;
         m_ov = 0; m_ol = 0; m_od = 0; m_och = 0; m_err = 0;
         chk_en = 1'b1;
      end else begin
         m_err = !m_locked && !mode && (sel >= 3);
         if (can) begin
            m_ov = acc;
            if (acc) begin
               m_od  = int'(in_data[c*8 +: 8]);
               m_ol  = in_last[c];
               m_och = c;
            end
         end
         if (acc) begin
            if (!m_locked) begin
               if (mode) m_ptr = c;
               if (!in_last[c]) begin
                  m_locked = 1;
                  m_gnt    = c;
               end
            end else if (in_last[c]) begin
               m_locked = 0;
            end
         end
      end
   end

   int lg_ch[$], lg_dat[$], lg_last[$], lg_cyc[$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(m_ready()));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         chk("err_sel", 32'(err_sel), 32'(m_err));
         if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_last", 32'(out_last), 32'(m_ol));
            chk("out_ch", 32'(out_ch), 32'(m_och));
         end
         if (out_valid && out_ready) begin
            lg_ch.push_back(int'(out_ch));
            lg_dat.push_back(int'(out_data));
            lg_last.push_back(int'(out_last));
            lg_cyc.push_back(cyc);
         end
      end
   end

   logic [8:0] chq [3][$];

   task automatic drive();
      for (int k = 0; k < 3; k++) begin
         if (chq[k].size() > 0) begin
            in_valid[k]        = 1'b1;
            in_data[k*8 +: 8]  = chq[k][0][7:0];
            in_last[k]         = chq[k][0][8];
         end else begin
            in_valid[k] = 1'b0;
            in_last[k]  = 1'b0;
         end
      end
   endtask

   task automatic run(input int n);
      logic [2:0] acc;
      repeat (n) begin
         drive();
         #1;
         acc = in_ready & in_valid;
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) if (acc[k]) void'(chq[k].pop_front());
      end
      drive();
      #1;
   endtask

   task automatic clear_log();
      lg_ch.delete(); lg_dat.delete(); lg_last.delete(); lg_cyc.delete();
   endtask

   task automatic chk_beat(input string tag, input int i, input int ch, input int dat, input int last);
      if (i < lg_ch.size()) begin
         chk({tag, "_ch"}, 32'(lg_ch[i]), 32'(ch));
         chk({tag, "_data"}, 32'(lg_dat[i]), 32'(dat));
         chk({tag, "_last"}, 32'(lg_last[i]), 32'(last));
      end else begin
         chk({tag, "_missing"}, 32'(lg_ch.size()), 32'(i + 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
      in_valid = '0; in_last = '0; in_data = '0;

      // Reset state, with in_ready held low while rst is asserted.
      run(2);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_ch", 32'(out_ch), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_err", 32'(err_sel), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;

      // Fixed select on channel 1, two-beat packet.
      mode = 1'b0; sel = 2'd1; clear_log();
      chq[1].push_back({1'b0, 8'h11});
      chq[1].push_back({1'b1, 8'h22});
      run(1);
      chk("fix_lat_valid", 32'(out_valid), 32'd1);
      chk("fix_lat_data", 32'(out_data), 32'h11);
      chk("fix_lat_ch", 32'(out_ch), 32'd1);
      run(1);
      chk("fix_b2_data", 32'(out_data), 32'h22);
      chk("fix_b2_last", 32'(out_last), 32'd1);
      run(2);
      chk("fix_count", 32'(lg_ch.size()), 32'd2);
      chk_beat("fix0", 0, 1, 8'h11, 0);
      chk_beat("fix1", 1, 1, 8'h22, 1);

      // Round-robin over single-beat packets.
      mode = 1'b1; sel = 2'd0; clear_log();
      chq[0].push_back({1'b1, 8'hA0});
      chq[0].push_back({1'b1, 8'hA1});
      chq[1].push_back({1'b1, 8'hB0});
      chq[2].push_back({1'b1, 8'hC0});
      run(6);
      chk("rr_count", 32'(lg_ch.size()), 32'd4);
      chk_beat("rr0", 0, 0, 8'hA0, 1);
      chk_beat("rr1", 1, 1, 8'hB0, 1);
      chk_beat("rr2", 2, 2, 8'hC0, 1);
      chk_beat("rr3", 3, 0, 8'hA1, 1);

      // Packet lock: ch0 three beats while ch1 waits.
      rst = 1'b1; run(1); rst = 1'b0;
      mode = 1'b1; clear_log();
      chq[0].push_back({1'b0, 8'h01});
      chq[0].push_back({1'b0, 8'h02});
      chq[0].push_back({1'b1, 8'h03});
      chq[1].push_back({1'b1, 8'h44});
      run(6);
      chk("lock_count", 32'(lg_ch.size()), 32'd4);
      chk_beat("lock0", 0, 0, 8'h01, 0);
      chk_beat("lock1", 1, 0, 8'h02, 0);
      chk_beat("lock2", 2, 0, 8'h03, 1);
      chk_beat("lock3", 3, 1, 8'h44, 1);
      if (lg_cyc.size() == 4) chk("lock_next_cycle", 32'(lg_cyc[3]), 32'(lg_cyc[2] + 1));

      // Backpressure mid-packet on ch2.
      mode = 1'b0; sel = 2'd2; clear_log();
      chq[2].push_back({1'b0, 8'h51});
      chq[2].push_back({1'b0, 8'h52});
      chq[2].push_back({1'b0, 8'h53});
      chq[2].push_back({1'b1, 8'h54});
      run(2);
      chk("bp_pre_data", 32'(out_data), 32'h52);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run(1);
         chk("bp_hold_data", 32'(out_data), 32'h52);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      run(4);
      chk("bp_count", 32'(lg_ch.size()), 32'd4);
      chk_beat("bp0", 0, 2, 8'h51, 0);
      chk_beat("bp1", 1, 2, 8'h52, 0);
      chk_beat("bp2", 2, 2, 8'h53, 0);
      chk_beat("bp3", 3, 2, 8'h54, 1);
      chk("bp_drained", 32'(chq[2].size()), 32'd0);

      // Out-of-range select.
      mode = 1'b0; sel = 2'd3;
      chq[0].push_back({1'b1, 8'h66});
      for (int i = 0; i < 2; i++) begin
         run(1);
         chk("bad_err", 32'(err_sel), 32'd1);
         chk("bad_in_ready", 32'(in_ready), 32'd0);
         chk("bad_out_valid", 32'(out_valid), 32'd0);
      end
      chq[0].delete();
      sel = 2'd0;
      run(1);
      chk("bad_err_clear", 32'(err_sel), 32'd0);

      // Reset while locked on ch2 with a pending output beat.
      mode = 1'b0; sel = 2'd2; out_ready = 1'b0;
      chq[2].push_back({1'b0, 8'h71});
      chq[2].push_back({1'b0, 8'h72});
      chq[2].push_back({1'b1, 8'h73});
      run(1);
      chk("mr_pending_valid", 32'(out_valid), 32'd1);
      chk("mr_pending_data", 32'(out_data), 32'h71);
      rst = 1'b1;
      run(1);
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      chq[2].delete();
      out_ready = 1'b1; mode = 1'b1; clear_log();
      chq[0].push_back({1'b1, 8'h90});
      chq[2].push_back({1'b1, 8'h92});
      run(4);
      chk("mr_count", 32'(lg_ch.size()), 32'd2);
      chk_beat("mr0", 0, 0, 8'h90, 1);
      chk_beat("mr1", 1, 2, 8'h92, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
